// File: rtl/btn_pulse_gen.sv
// Two-channel push-button conditioner: 2-FF synchroniser, debounce FSM, one-shot with left priority.
// Define AUTO_REPEAT_EN to re-trigger every REPEAT_CYCLES while a button stays held.
module btn_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_CYCLES   = 50000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_l_raw,
    input  logic btn_r_raw,
    output logic pulse_l,
    output logic pulse_r,
    output logic level_l,
    output logic level_r
);

    typedef enum logic [1:0] {
        StIdleLo,
        StWaitHi,
        StStableHi,
        StWaitLo
    } state_e;

    localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    // The counter is shared in width by debounce and repeat timing, so it must cover both.
    localparam longint unsigned MaxCycles =
        (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? longint'(DEBOUNCE_CYCLES) : longint'(REPEAT_CYCLES);
    if ((MaxCycles - 1) >= (64'd1 << CNT_W)) begin : g_cnt_w_check
        $error("CNT_W too narrow for DEBOUNCE_CYCLES/REPEAT_CYCLES");
    end

    // Index 0 is the left channel, index 1 the right channel.
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    state_e           state_q [2];
    state_e           state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [1:0]       level_q;
    logic [1:0]       level_d;
    logic [1:0]       rise;
    logic             pulse_l_q;
    logic             pulse_r_q;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RepLast = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_q [2];
    logic [CNT_W-1:0] rep_d [2];
`endif

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            level_d[i] = level_q[i];
            rise[i]    = 1'b0;
            unique case (state_q[i])
                StIdleLo: begin
                    if (sync2_q[i]) begin
                        state_d[i] = StWaitHi;
                        cnt_d[i]   = '0;
                    end
                end
                StWaitHi: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StIdleLo;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DebLast) begin
                        state_d[i] = StStableHi;
                        level_d[i] = 1'b1;
                        rise[i]    = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                StStableHi: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StWaitLo;
                        cnt_d[i]   = '0;
                    end
                end
                StWaitLo: begin
                    // A bounce back high returns to the held state without a new pulse.
                    if (sync2_q[i]) begin
                        state_d[i] = StStableHi;
                    end else if (cnt_q[i] == DebLast) begin
                        state_d[i] = StIdleLo;
                        level_d[i] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = StIdleLo;
                end
            endcase
`ifdef AUTO_REPEAT_EN
            rep_d[i] = '0;
            if (state_q[i] == StStableHi && sync2_q[i]) begin
                if (rep_q[i] == RepLast) begin
                    rise[i] = 1'b1;
                end else begin
                    rep_d[i] = rep_q[i] + 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            pulse_l_q <= 1'b0;
            pulse_r_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StIdleLo;
                cnt_q[i]   <= '0;
`ifdef AUTO_REPEAT_EN
                rep_q[i]   <= '0;
`endif
            end
        end else begin
            sync1_q   <= {btn_r_raw, btn_l_raw};
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            pulse_l_q <= rise[0];
            pulse_r_q <= rise[1] & ~rise[0];
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef AUTO_REPEAT_EN
                rep_q[i]   <= rep_d[i];
`endif
            end
        end
    end

    assign pulse_l = pulse_l_q;
    assign pulse_r = pulse_r_q;
    assign level_l = level_q[0];
    assign level_r = level_q[1];

endmodule
